// File: rtl/viterbi_traceback.sv
// Viterbi traceback: walks survivor pointers backward, buffers decoded bits, replays them oldest-first.
// Optional VITERBI_TB_BEST_STATE_EN: start traceback from i_start_st instead of state 0.
module viterbi_traceback #(
  parameter int STATE_NUM = 256,
  parameter int STATE_W   = 8,
  parameter int TB_DEPTH  = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_sync,
  input  logic                                  i_vld,
  input  logic [STATE_NUM-1:0][STATE_W-1:0]     i_prv_st,
  input  logic [STATE_W-1:0]                    i_start_st,
  input  logic                                  i_rdy,
  output logic                                  o_bit,
  output logic                                  o_valid,
  output logic                                  o_busy,
  output logic                                  o_done
);

  // state | meaning
  // IDLE  | waiting for survivor memory sync
  // TRACE | one pointer hop per valid step, capturing a bit each hop
  // OUT   | replaying captured bits, oldest first, under valid/ready
  // DONE  | frame emitted; held until reset
  typedef enum logic [1:0] {IDLE, TRACE, OUT, DONE} state_t;

  localparam int CNT_W = $clog2(TB_DEPTH) + 1;
  localparam int IDX_W = CNT_W - 1;

  state_t              state, state_nxt;
  logic [STATE_W-1:0]  cur_st;
  logic [STATE_W-1:0]  start_st;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    rd;
  logic [TB_DEPTH-1:0] bit_buf;
  logic                step, last_step, xfer, last_xfer;

`ifdef VITERBI_TB_BEST_STATE_EN
  assign start_st = i_start_st;
`else
  // Zero-terminated trellis: the port stays for interface stability only.
  logic unused_start_st;
  assign unused_start_st = ^i_start_st;
  assign start_st        = '0;
`endif

  assign step      = (state == TRACE) && i_vld;
  assign last_step = step && (cnt == CNT_W'(TB_DEPTH - 1));
  assign xfer      = (state == OUT) && i_rdy;
  assign last_xfer = xfer && (rd == '0);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_sync)    state_nxt = TRACE;
      TRACE:   if (last_step) state_nxt = OUT;
      OUT:     if (last_xfer) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_st <= '0;
      cnt    <= '0;
      rd     <= '0;
    end else begin
      case (state)
        IDLE: if (i_sync) begin
          cur_st <= start_st;
          cnt    <= '0;
        end
        TRACE: if (step) begin
          cur_st <= i_prv_st[cur_st];
          cnt    <= cnt + CNT_W'(1);
          if (last_step) rd <= CNT_W'(TB_DEPTH - 1);
        end
        OUT: if (xfer && (rd != '0)) rd <= rd - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Bit store needs no reset: it is fully rewritten before any replay.
  always_ff @(posedge clk) begin
    if (step) bit_buf[cnt[IDX_W-1:0]] <= cur_st[STATE_W-1];
  end

  assign o_valid = (state == OUT);
  assign o_bit   = o_valid & bit_buf[rd[IDX_W-1:0]];
  assign o_busy  = (state == TRACE) || (state == OUT);
  assign o_done  = (state == DONE);

endmodule
